// File: rtl/mtl2_timer_sequencer_pkg.sv
// mtl2_timer_pkg: shared definitions for the MTL2 interval-timer sequencer.
//   - Timer slave register addresses (16-bit register map).
//   - Control register bit masks.
//   - Sequencer FSM state type.
//   - calc_period(): programmed period = max(delay, min_delay) - 1, never wraps below 0.
package mtl2_timer_pkg;

  localparam logic [2:0] TMR_ADDR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_ADDR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_ADDR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_ADDR_PERIODH = 3'd3;

  localparam logic [15:0] CTRL_ITO   = 16'h0001;
  localparam logic [15:0] CTRL_CONT  = 16'h0002;
  localparam logic [15:0] CTRL_START = 16'h0004;
  localparam logic [15:0] CTRL_STOP  = 16'h0008;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_STOP,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTRL,
    S_WAIT_IRQ,
    S_WD_STOP,
    S_CLR,
    S_DONE
  } seq_state_t;

  function automatic logic [31:0] calc_period(input logic [31:0] delay,
                                              input logic [31:0] min_delay);
    logic [31:0] eff;
    eff = (delay < min_delay) ? min_delay : delay;
    return (eff == 32'd0) ? 32'd0 : eff - 32'd1;
  endfunction

endpackage

// File: rtl/mtl2_timer_sequencer_if.sv
// mtl2_timer_sequencer_if: Avalon-MM write-only link to the MTL2 timer slave.
//   address    [2:0]  timer register address
//   chipselect        timer select
//   write_n           active-low write strobe (asserted together with chipselect)
//   writedata  [15:0] register write data
//   irq               timer interrupt back to the master
// Modports: master (sequencer side), slave (timer side).
interface mtl2_timer_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata, input irq);
  modport slave  (input address, chipselect, write_n, writedata, output irq);
endinterface

// File: rtl/mtl2_timer_sequencer_arbiter.sv
// mtl2_rr_arbiter: combinational round-robin pick.
//   req       [NUM_REQ-1:0] request vector
//   ptr       [IDW-1:0]     highest-priority index this round (must be < NUM_REQ)
//   gnt_oh    [NUM_REQ-1:0] one-hot grant
//   gnt_idx   [IDW-1:0]     index of the granted requester
//   gnt_valid               any request present
module mtl2_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDW-1:0]     gnt_idx,
  output logic               gnt_valid
);

  // Walk from the farthest slot back to ptr so the nearest set bit wins.
  always_comb begin
    int j;
    logic [IDW-1:0] jj;
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    j         = 0;
    jj        = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IDW'(j);
      if (req[jj]) begin
        gnt_oh     = '0;
        gnt_oh[jj] = 1'b1;
        gnt_idx    = jj;
        gnt_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mtl2_timer_sequencer.sv
// mtl2_timer_sequencer: shares the MTL2 one-shot interval timer among NUM_REQ
// requesters. Round-robin grant, program period, start, wait for irq, clear
// status, pulse done to the owner.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req      [NUM_REQ]    level request, held until done
//   delay    [NUM_REQ*32] packed delays, requester i at [32i+31:32i]
//   done     [NUM_REQ]    one-cycle completion pulse
//   busy                  high from grant to done
//   grant_id [IDW]        current owner, valid while busy
//   tmr                   timer bus (mtl2_timer_sequencer_if.master)
//   err                   watchdog expiry pulse (only with MTL2_TMR_SEQ_WDOG_EN)
//
// Optional macro MTL2_TMR_SEQ_WDOG_EN: WAIT_IRQ watchdog of WDOG_CYCLES cycles;
// on expiry err pulses, the timer is stopped and cleared, and done still pulses.
//
// Bus outputs are registered from the next state, so the state name equals
// the write on the bus during that state.
//   state      | meaning
//   S_IDLE     | bus idle, waiting for a request
//   S_WR_STOP  | control <= STOP
//   S_WR_PL    | period_l <= period[15:0]
//   S_WR_PH    | period_h <= period[31:16]
//   S_WR_CTRL  | control <= ITO|START (one-shot)
//   S_WAIT_IRQ | bus idle, waiting for timer irq
//   S_WD_STOP  | watchdog expired: control <= STOP
//   S_CLR      | status <= 0 (clears TO)
//   S_DONE     | done pulse to owner, busy low
module mtl2_timer_sequencer
  import mtl2_timer_pkg::*;
#(
  parameter int          NUM_REQ     = 4,
  parameter int          MIN_DELAY   = 2,
  parameter logic [31:0] WDOG_CYCLES = 32'hFFFF_FFFF,
  localparam int         IDW         = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*32-1:0]  delay,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id,
  mtl2_timer_sequencer_if.master tmr
`ifdef MTL2_TMR_SEQ_WDOG_EN
  ,
  output logic                   err
`endif
);

  seq_state_t state_q, state_d;

  logic [IDW-1:0]     ptr_q, ptr_next;
  logic [IDW-1:0]     grant_q;
  logic [31:0]        period_q;
  logic               busy_q;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               cs_q, cs_d;
  logic [2:0]         addr_q, addr_d;
  logic [15:0]        data_q, data_d;

  logic [NUM_REQ-1:0] arb_oh;
  logic [IDW-1:0]     arb_idx;
  logic               arb_valid;
  logic [31:0]        sel_delay;
  logic               wdog_hit;

  mtl2_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_oh    (arb_oh),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  // AND-OR mux of the granted requester's delay.
  always_comb begin
    sel_delay = '0;
    for (int i = 0; i < NUM_REQ; i++)
      sel_delay = sel_delay | ({32{arb_oh[i]}} & delay[i*32 +: 32]);
  end

  assign ptr_next = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);

`ifdef MTL2_TMR_SEQ_WDOG_EN
  logic [31:0] wdog_q;
  logic        err_q;

  assign wdog_hit = (wdog_q == WDOG_CYCLES);
  assign err      = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= (state_q == S_WAIT_IRQ) ? wdog_q + 32'd1 : 32'd0;
      err_q  <= (state_d == S_WD_STOP);
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cs_d    = 1'b0;
    addr_d  = TMR_ADDR_STATUS;
    data_d  = '0;
    done_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          state_d = S_WR_STOP;
          cs_d    = 1'b1;
          addr_d  = TMR_ADDR_CONTROL;
          data_d  = CTRL_STOP;
        end
      end
      S_WR_STOP: begin
        state_d = S_WR_PL;
        cs_d    = 1'b1;
        addr_d  = TMR_ADDR_PERIODL;
        data_d  = period_q[15:0];
      end
      S_WR_PL: begin
        state_d = S_WR_PH;
        cs_d    = 1'b1;
        addr_d  = TMR_ADDR_PERIODH;
        data_d  = period_q[31:16];
      end
      S_WR_PH: begin
        state_d = S_WR_CTRL;
        cs_d    = 1'b1;
        addr_d  = TMR_ADDR_CONTROL;
        data_d  = CTRL_ITO | CTRL_START;
      end
      S_WR_CTRL: state_d = S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        if (tmr.irq) begin
          state_d = S_CLR;
          cs_d    = 1'b1;
          addr_d  = TMR_ADDR_STATUS;
        end else if (wdog_hit) begin
          state_d = S_WD_STOP;
          cs_d    = 1'b1;
          addr_d  = TMR_ADDR_CONTROL;
          data_d  = CTRL_STOP;
        end
      end
      S_WD_STOP: begin
        state_d = S_CLR;
        cs_d    = 1'b1;
        addr_d  = TMR_ADDR_STATUS;
      end
      S_CLR: begin
        state_d          = S_DONE;
        done_d[grant_q]  = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      period_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= '0;
      cs_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      if (state_q == S_IDLE && arb_valid) begin
        grant_q  <= arb_idx;
        period_q <= calc_period(sel_delay, 32'(MIN_DELAY));
        busy_q   <= 1'b1;
      end else if (state_d == S_DONE) begin
        busy_q <= 1'b0;
      end
      if (state_q == S_CLR)
        ptr_q <= ptr_next;
    end
  end

  assign done           = done_q;
  assign busy           = busy_q;
  assign grant_id       = grant_q;
  assign tmr.chipselect = cs_q;
  assign tmr.write_n    = ~cs_q;
  assign tmr.address    = addr_q;
  assign tmr.writedata  = data_q;

endmodule

// File: tb/tb_mtl2_timer_sequencer.sv
// Testbench for mtl2_timer_sequencer: the bench plays the timer (drives irq a
// chosen number of cycles after the start write) and checks bus writes, done
// pulses and grant order against a round-robin/period model.
module tb_mtl2_timer_sequencer;
  import mtl2_timer_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int MIN_DELAY = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   req = '0;
  logic [127:0] delay = '0;
  logic [3:0]   done;
  logic         busy;
  logic [1:0]   grant_id;
`ifdef MTL2_TMR_SEQ_WDOG_EN
  logic         err;
`endif

  mtl2_timer_sequencer_if tmr_if ();

  mtl2_timer_sequencer #(.NUM_REQ(NUM_REQ), .MIN_DELAY(MIN_DELAY)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .delay    (delay),
    .done     (done),
    .busy     (busy),
    .grant_id (grant_id),
    .tmr      (tmr_if.master)
`ifdef MTL2_TMR_SEQ_WDOG_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int model_ptr = 0;

  int          n_wr, ctrl_cyc, irq_cyc, clr_cyc, done_cyc;
  logic [2:0]  wr_addr [8];
  logic [15:0] wr_data [8];
  int          wr_cyc  [8];
  logic [3:0]  done_val;
  logic [1:0]  gid_obs;
  bit          busy_bad, done_stuck, timed_out;

  function automatic logic [31:0] model_period(input logic [31:0] d);
    logic [31:0] e;
    e = (d < MIN_DELAY) ? MIN_DELAY : d;
    return e - 1;
  endfunction

  function automatic int model_pick(input logic [3:0] r);
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (model_ptr + k) % NUM_REQ;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    delay = '0;
    tmr_if.irq = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_ptr = 0;
    @(negedge clk);
  endtask

  // Plays the timer for one operation and records what the DUT did.
  task automatic observe_op(input int irq_after, input bit stale, input logic [3:0] clr_mask);
    n_wr = 0; ctrl_cyc = -1; irq_cyc = -1; clr_cyc = -1; done_cyc = -1;
    done_val = '0; gid_obs = '0; busy_bad = 0; done_stuck = 0; timed_out = 1;
    for (int t = 0; t < 3000 && timed_out; t++) begin
      @(negedge clk);
      if (tmr_if.chipselect && !tmr_if.write_n) begin
        if (n_wr < 8) begin
          wr_addr[n_wr] = tmr_if.address;
          wr_data[n_wr] = tmr_if.writedata;
          wr_cyc[n_wr]  = cyc;
        end
        if (n_wr == 0) gid_obs = grant_id;
        n_wr++;
        if (stale && n_wr == 2) tmr_if.irq = 1'b1;
        if (tmr_if.address == TMR_ADDR_CONTROL && tmr_if.writedata == 16'h0005) begin
          ctrl_cyc = cyc;
          tmr_if.irq = 1'b0;
        end
        if (tmr_if.address == TMR_ADDR_STATUS) begin
          clr_cyc = cyc;
          tmr_if.irq = 1'b0;
        end
      end
      if (n_wr > 0 && done == '0 && !busy) busy_bad = 1;
      if (ctrl_cyc >= 0 && irq_cyc < 0 && cyc == ctrl_cyc + irq_after) begin
        tmr_if.irq = 1'b1;
        irq_cyc = cyc;
      end
      if (done != '0) begin
        done_val  = done;
        done_cyc  = cyc;
        timed_out = 0;
        req = req & ~clr_mask;
        @(negedge clk);
        done_stuck = (done != '0);
      end
    end
    tmr_if.irq = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] exp_v, got_v;
    exp_v = {1'b0, 4'h0, 1'b0, 1'b1, 3'h0, 16'h0, 2'h0};
    reset_n = 1'b0; req = '0; tmr_if.irq = 1'b1;
    @(negedge clk);
    got_v = {busy, done, tmr_if.chipselect, tmr_if.write_n, tmr_if.address, tmr_if.writedata, grant_id};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", got_v, exp_v);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    got_v = {busy, done, tmr_if.chipselect, tmr_if.write_n, tmr_if.address, tmr_if.writedata, grant_id};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL idle_with_stale_irq got=%h exp=%h", got_v, exp_v);
    end
    tmr_if.irq = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] p;
    logic [2:0]  exp_a [5];
    logic [15:0] exp_d [5];
    int r, pick;
    do_reset();
    p = model_period(100);
    exp_a = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd0};
    exp_d = '{16'h0008, p[15:0], p[31:16], 16'h0005, 16'h0000};
    r = cyc;
    req = 4'b0001;
    delay[31:0] = 32'd100;
    pick = model_pick(req);
    observe_op(int'(p) + 1, 1'b0, 4'b0001);
    model_ptr = (pick + 1) % NUM_REQ;
    checks++;
    if (timed_out || n_wr !== 5) begin
      failures++;
      $display("FAIL single_write_count got=%0d exp=5 timed_out=%0d", n_wr, timed_out);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wr_addr[i] !== exp_a[i] || wr_data[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL single_write%0d got=(%0d,%h) exp=(%0d,%h)", i, wr_addr[i], wr_data[i], exp_a[i], exp_d[i]);
      end
    end
    checks++;
    if (wr_cyc[0] !== r + 1 || wr_cyc[3] !== r + 4) begin
      failures++;
      $display("FAIL single_write_latency got=%0d,%0d exp=%0d,%0d", wr_cyc[0] - r, wr_cyc[3] - r, 1, 4);
    end
    checks++;
    if (clr_cyc !== irq_cyc + 1 || done_cyc !== irq_cyc + 2) begin
      failures++;
      $display("FAIL single_irq_latency got clr=+%0d done=+%0d exp clr=+1 done=+2", clr_cyc - irq_cyc, done_cyc - irq_cyc);
    end
    checks++;
    if (done_val !== 4'(1 << pick) || gid_obs !== 2'(pick)) begin
      failures++;
      $display("FAIL single_done got=%b gid=%0d exp=%b gid=%0d", done_val, gid_obs, 4'(1 << pick), pick);
    end
    checks++;
    if (busy_bad || done_stuck) begin
      failures++;
      $display("FAIL single_busy_done_pulse got busy_bad=%0d done_stuck=%0d exp 0 0", busy_bad, done_stuck);
    end
  endtask

  task automatic test_clamp();
    logic [31:0] p;
    int id, pick;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      id = $urandom_range(0, 3);
      req = 4'(1 << id);
      delay[id*32 +: 32] = 32'(k);
      p = model_period(32'(k));
      pick = model_pick(req);
      observe_op(int'(p) + 1, 1'b0, req);
      model_ptr = (pick + 1) % NUM_REQ;
      checks++;
      if (wr_data[1] !== p[15:0] || wr_data[2] !== p[31:16] || done_val !== 4'(1 << pick)) begin
        failures++;
        $display("FAIL clamp_delay%0d got pl=%h ph=%h done=%b exp pl=%h ph=%h done=%b",
                 k, wr_data[1], wr_data[2], done_val, p[15:0], p[31:16], 4'(1 << pick));
      end
    end
  endtask

  task automatic test_wide();
    logic [31:0] ds [4];
    logic [31:0] p;
    int id;
    do_reset();
    ds = '{32'h0002_0000, 32'hFFFF_FFFF, $urandom, $urandom};
    for (int k = 0; k < 4; k++) begin
      id = $urandom_range(0, 3);
      req = 4'(1 << id);
      delay[id*32 +: 32] = ds[k];
      p = model_period(ds[k]);
      observe_op(3, 1'b0, req);
      checks++;
      if (timed_out || wr_data[1] !== p[15:0] || wr_data[2] !== p[31:16]) begin
        failures++;
        $display("FAIL wide_delay%0d d=%h got pl=%h ph=%h exp pl=%h ph=%h",
                 k, ds[k], wr_data[1], wr_data[2], p[15:0], p[31:16]);
      end
    end
  endtask

  task automatic test_round_robin();
    int pick;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) delay[i*32 +: 32] = 32'd10;
    req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      pick = model_pick(req);
      observe_op(int'(model_period(32'd10)) + 1, 1'b0, (k == 3) ? 4'hF : 4'h0);
      model_ptr = (pick + 1) % NUM_REQ;
      checks++;
      if (done_val !== 4'(1 << pick) || gid_obs !== 2'(pick) || done_stuck) begin
        failures++;
        $display("FAIL rr_op%0d got done=%b gid=%0d exp done=%b gid=%0d", k, done_val, gid_obs, 4'(1 << pick), pick);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] p;
    int pick, n_ops;
    do_reset();
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < NUM_REQ; i++) delay[i*32 +: 32] = 32'($urandom_range(0, 40));
      req = 4'($urandom_range(1, 15));
      n_ops = 0;
      while (req != '0 && n_ops < 4) begin
        pick = model_pick(req);
        p = model_period(delay[pick*32 +: 32]);
        observe_op(int'(p) + 1, 1'b0, 4'(1 << pick));
        model_ptr = (pick + 1) % NUM_REQ;
        n_ops++;
        checks++;
        if (timed_out || done_val !== 4'(1 << pick) || wr_data[1] !== p[15:0]) begin
          failures++;
          $display("FAIL random_r%0d_op%0d got done=%b pl=%h exp done=%b pl=%h",
                   round, n_ops, done_val, wr_data[1], 4'(1 << pick), p[15:0]);
          req = '0;
        end
      end
    end
  endtask

  task automatic test_stale_irq();
    logic [31:0] p;
    do_reset();
    req = 4'b0010;
    delay[63:32] = 32'd20;
    p = model_period(32'd20);
    observe_op(int'(p) + 1, 1'b1, 4'b0010);
    checks++;
    if (n_wr !== 5 || wr_addr[4] !== TMR_ADDR_STATUS) begin
      failures++;
      $display("FAIL stale_irq_writes got n=%0d last_addr=%0d exp n=5 last_addr=0", n_wr, wr_addr[4]);
    end
    checks++;
    if (done_cyc !== ctrl_cyc + int'(p) + 3 || done_val !== 4'b0010) begin
      failures++;
      $display("FAIL stale_irq_done got cyc=+%0d done=%b exp cyc=+%0d done=0010",
               done_cyc - ctrl_cyc, done_val, int'(p) + 3);
    end
  endtask

  task automatic test_reset_mid();
    bit seen, bad;
    int r;
    logic [31:0] p;
    do_reset();
    req = 4'b0010;
    delay[63:32] = 32'd50;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (tmr_if.chipselect && !tmr_if.write_n && tmr_if.address == TMR_ADDR_CONTROL &&
          tmr_if.writedata == 16'h0005) seen = 1;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!seen || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_setup got ctrl_seen=%0d busy=%b exp 1 1", seen, busy);
    end
    reset_n = 1'b0;
    req = '0;
    #1;
    checks++;
    if ({busy, done, tmr_if.chipselect, tmr_if.write_n, grant_id} !== 9'b0_0000_0_1_00) begin
      failures++;
      $display("FAIL reset_mid_async got=%b exp=%b",
               {busy, done, tmr_if.chipselect, tmr_if.write_n, grant_id}, 9'b0_0000_0_1_00);
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done != '0 || busy || tmr_if.chipselect) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_mid_hold got activity=1 exp activity=0");
    end
    reset_n = 1'b1;
    model_ptr = 0;
    @(negedge clk);
    r = cyc;
    req = 4'b0100;
    delay[95:64] = 32'd7;
    p = model_period(32'd7);
    observe_op(int'(p) + 1, 1'b0, 4'b0100);
    checks++;
    if (timed_out || done_val !== 4'b0100 || gid_obs !== 2'd2 || wr_cyc[0] !== r + 1 || wr_data[1] !== p[15:0]) begin
      failures++;
      $display("FAIL reset_mid_reuse got done=%b gid=%0d start=+%0d pl=%h exp done=0100 gid=2 start=+1 pl=%h",
               done_val, gid_obs, wr_cyc[0] - r, wr_data[1], p[15:0]);
    end
  endtask

  initial begin
    tmr_if.irq = 1'b0;
    test_reset();
    test_single();
    test_clamp();
    test_wide();
    test_round_robin();
    test_random();
    test_stale_irq();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mtl2_timer_sequencer.md
Name: mtl2_timer_sequencer

Overview:
Avalon-MM master that shares the MTL2 interval timer (16-bit register map, one-shot mode) among NUM_REQ requesters, such as touch-poll, LCD refresh pacing and UI debounce.
- Arbitrates requests round-robin.
- Programs the granted delay into the timer's period registers and starts it.
- Waits for the timer irq, clears the timer status, then pulses done to the owner.
- Sits between the painter control logic and the timer's slave port; it is the timer's only master.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MIN_DELAY, 2, smallest delay in clk cycles; smaller requests are clamped to this
WDOG_CYCLES, 32'hFFFF_FFFF, watchdog limit in WAIT_IRQ (used only with the macro)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  level request per requester; held until its done pulse
delay  in  NUM_REQ*32  packed delay in cycles, requester i at [32i+31:32i]
done  out  NUM_REQ  one-cycle completion pulse to the granted requester
busy  out  1  high from grant to done
grant_id  out  clog2(NUM_REQ)  index of the current owner, valid while busy
tmr_address  out  3  timer register address
tmr_chipselect  out  1  timer select
tmr_write_n  out  1  active-low write strobe
tmr_writedata  out  16  timer write data
tmr_irq  in  1  timer interrupt
err  out  1  watchdog expiry pulse (present only with the macro)

Behaviour:
- Reset values, all registered outputs: done=0, busy=0, grant_id=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0, err=0, rr pointer=0, state=IDLE.
- Timer register map: addr0 status (write clears TO); addr1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP); addr2 period_l; addr3 period_h.
- Bus rules: writes only, one cycle each, no waitrequest. tmr_chipselect and ~tmr_write_n are asserted together.
- FSM:
  - IDLE: if any req, pick the first set bit at or after rr pointer (wrapping). Latch grant_id and the delay. Compute period = max(delay, MIN_DELAY) - 1, 32-bit and saturating. Set busy=1 and go to WR_STOP.
  - WR_STOP: addr1, data 16'h0008 (stops any stale count).
  - WR_PL: addr2, data period[15:0].
  - WR_PH: addr3, data period[31:16].
  - WR_CTRL: addr1, data 16'h0005 (ITO|START, CONT=0, one-shot).
  - WAIT_IRQ: bus idle. When tmr_irq is sampled high, go to CLR.
  - CLR: addr0, data 0 (clears TO, so irq drops).
  - DONE: done[grant_id]=1 for one cycle, busy=0, rr pointer = grant_id+1 mod NUM_REQ, then IDLE.
- Latency: req seen at edge 0 gives writes in cycles 1–4. Timer timeout occurs period+1 cycles after the WR_CTRL edge. If irq is sampled at edge k, CLR is on the bus in cycle k+1 and done is high in cycle k+2.
- Requests are not pre-empted. A requester dropping req mid-operation is ignored: the operation completes and done still pulses.
- Simultaneous requests are served in round-robin order. A requester whose req is still high after its done waits for all other pending requesters.
- tmr_irq high outside WAIT_IRQ is ignored (stale interrupt). WR_STOP followed by CLR before reuse is the recovery path.
- Reset mid-operation returns everything to reset values immediately. No done is issued for the aborted request.

Optional Feature:
Macro MTL2_TMR_SEQ_WDOG_EN.
- Defined: a 32-bit counter runs in WAIT_IRQ. When it reaches WDOG_CYCLES:
  - pulse err one cycle;
  - write STOP (addr1, 16'h0008), then CLR;
  - pulse done[grant_id] as normal.
- Not defined: no counter, the err port is absent, and WAIT_IRQ waits indefinitely.

Decomposition:
- Package mtl2_timer_pkg holds:
  - register address constants TMR_ADDR_STATUS/CONTROL/PERIODL/PERIODH;
  - control bit constants CTRL_ITO/CONT/START/STOP;
  - the FSM state typedef.
- One sub-module, mtl2_rr_arbiter: combinational round-robin pick from req and pointer, producing a one-hot grant and its index.

Test Plan:
- Single request: req[0]=1, delay=100. Bus shows (1,0008), (2,0063), (3,0000), (1,0005). Drive irq 100 cycles after WR_CTRL. Expect CLR (0,0000) next cycle and done[0] one cycle later.
- Clamp: delay=0. Expect period_l=0001 and period_h=0000.
- 32-bit delay: delay=32'h0002_0000. Expect period_l=FFFF and period_h=0001.
- Round-robin: req=4'b1011 held, delays 10. Expect grant order 0,1,3,0; done pulses one-hot in that order.
- Stale irq: tmr_irq high during WR_PL. Expect no early exit; done only after an irq seen in WAIT_IRQ.
- Reset mid-WAIT_IRQ: assert reset_n=0. Expect busy=0, no done, bus idle. After release, a new req[2] is served with rr pointer=0 order.
